// File: rtl/dest_demux_fifos_pkg.sv
// Shared definitions for the destination demux / output FIFO stage.
// Holds the default geometry of the block and the destination-bit encoding
// used by the write router.
package dest_demux_fifos_pkg;

  localparam int WIDTH     = 6;  // data word width
  localparam int DEPTH     = 4;  // entries per output FIFO, power of two
  localparam int DEST_BIT  = 4;  // bit of the word that selects D0 / D1
  localparam int AF_THRESH = 3;  // almost-full level driving the pause outputs

  // Value of data_in[DEST_BIT] that selects each output FIFO
  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

endpackage

// File: rtl/dest_demux_fifos_fifo_sync.sv
// fifo_sync: single-clock FIFO with a registered read port.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   wr_en, wr_data   : write request and word
//   rd_en            : read request; ignored while empty
//   rd_data          : registered head word, loaded on an accepted read
//   rd_valid         : 1 in the cycle after an accepted read
//   empty, full      : combinational decodes of count
//   count            : current occupancy, 0..DEPTH
//   overflow         : write attempted while full (word is dropped)
module fifo_sync
  import dest_demux_fifos_pkg::*;
#(
  parameter int WIDTH = dest_demux_fifos_pkg::WIDTH,
  parameter int DEPTH = dest_demux_fifos_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Flag decode and accept logic; both decisions use the pre-edge count,
  // so a pop on a full FIFO still drops a concurrent write.
  always_comb begin
    empty    = (count == CNT_W'(0));
    full     = (count == CNT_W'(DEPTH));
    do_wr    = wr_en & ~full;
    do_rd    = rd_en & ~empty;
    overflow = wr_en & full;
  end

  // Storage array; no reset needed since count gates every read of it.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers (wrap naturally at DEPTH), occupancy and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;  // idle, or write and read cancel out
      endcase
    end
  end

endmodule

// File: rtl/dest_demux_fifos.sv
// dest_demux_fifos: routes each word popped by the VC arbiter into one of
// two output FIFOs (D0/D1) by its destination bit, and feeds back
// almost-full pause signals that the arbiter samples in the same cycle.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   data_in, valid_in       : word from the arbiter mux and its valid
//   D0_pop, D1_pop          : read requests per FIFO
//   Dx_data_out, Dx_valid   : registered read data / valid per FIFO
//   Dx_empty, Dx_full       : combinational occupancy flags
//   Dx_pause                : count >= AF_THRESH, combinational
//   error                   : sticky, set by any write to a full FIFO
module dest_demux_fifos
  import dest_demux_fifos_pkg::*;
#(
  parameter int WIDTH     = dest_demux_fifos_pkg::WIDTH,
  parameter int DEPTH     = dest_demux_fifos_pkg::DEPTH,
  parameter int DEST_BIT  = dest_demux_fifos_pkg::DEST_BIT,
  parameter int AF_THRESH = dest_demux_fifos_pkg::AF_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             D0_pop,
  input  logic             D1_pop,
  output logic [WIDTH-1:0] D0_data_out,
  output logic [WIDTH-1:0] D1_data_out,
  output logic             D0_valid,
  output logic             D1_valid,
  output logic             D0_empty,
  output logic             D1_empty,
  output logic             D0_full,
  output logic             D1_full,
  output logic             D0_pause,
  output logic             D1_pause,
  output logic             error
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             d0_wr;
  logic             d1_wr;
  logic [CNT_W-1:0] d0_count;
  logic [CNT_W-1:0] d1_count;
  logic             d0_overflow;
  logic             d1_overflow;

  // Write demux: exactly one FIFO sees each valid word.
  always_comb begin
    d0_wr = 1'b0;
    d1_wr = 1'b0;
    if (valid_in) begin
      if (data_in[DEST_BIT] == DEST_D0) begin
        d0_wr = 1'b1;
      end else begin
        d1_wr = 1'b1;
      end
    end else begin
      d0_wr = 1'b0;
      d1_wr = 1'b0;
    end
  end

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_d0 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (d0_wr),
    .wr_data  (data_in),
    .rd_en    (D0_pop),
    .rd_data  (D0_data_out),
    .rd_valid (D0_valid),
    .empty    (D0_empty),
    .full     (D0_full),
    .count    (d0_count),
    .overflow (d0_overflow)
  );

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_d1 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (d1_wr),
    .wr_data  (data_in),
    .rd_en    (D1_pop),
    .rd_data  (D1_data_out),
    .rd_valid (D1_valid),
    .empty    (D1_empty),
    .full     (D1_full),
    .count    (d1_count),
    .overflow (d1_overflow)
  );

  // Pause must be combinational: the arbiter decides its pop this cycle.
  always_comb begin
    D0_pause = (d0_count >= CNT_W'(AF_THRESH));
    D1_pause = (d1_count >= CNT_W'(AF_THRESH));
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (d0_overflow || d1_overflow) begin
      error <= 1'b1;
    end else begin
      error <= error;
    end
  end

endmodule

// File: tb/tb_dest_demux_fifos.sv
// Directed self-checking bench for dest_demux_fifos.
module tb_dest_demux_fifos;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         D0_pop, D1_pop;
  logic [W-1:0] D0_data_out, D1_data_out;
  logic         D0_valid, D1_valid;
  logic         D0_empty, D1_empty;
  logic         D0_full, D1_full;
  logic         D0_pause, D1_pause;
  logic         error;

  int n_checks = 0;
  int n_fails  = 0;

  dest_demux_fifos dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .D0_pop      (D0_pop),
    .D1_pop      (D1_pop),
    .D0_data_out (D0_data_out),
    .D1_data_out (D1_data_out),
    .D0_valid    (D0_valid),
    .D1_valid    (D1_valid),
    .D0_empty    (D0_empty),
    .D1_empty    (D1_empty),
    .D0_full     (D0_full),
    .D1_full     (D1_full),
    .D0_pause    (D0_pause),
    .D1_pause    (D1_pause),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic p0, input logic p1);
    valid_in = v;
    data_in  = d;
    D0_pop   = p0;
    D1_pop   = p1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".D0_data_out"}, 32'(D0_data_out), 32'h0);
    check_eq({tag, ".D1_data_out"}, 32'(D1_data_out), 32'h0);
    check_eq({tag, ".D0_valid"},    32'(D0_valid),    32'h0);
    check_eq({tag, ".D1_valid"},    32'(D1_valid),    32'h0);
    check_eq({tag, ".error"},       32'(error),       32'h0);
    check_eq({tag, ".D0_empty"},    32'(D0_empty),    32'h1);
    check_eq({tag, ".D1_empty"},    32'(D1_empty),    32'h1);
    check_eq({tag, ".D0_full"},     32'(D0_full),     32'h0);
    check_eq({tag, ".D1_full"},     32'(D1_full),     32'h0);
    check_eq({tag, ".D0_pause"},    32'(D0_pause),    32'h0);
    check_eq({tag, ".D1_pause"},    32'(D1_pause),    32'h0);
  endtask

  logic [W-1:0] stream [10];

  initial begin
    // ---------------- reset with random inputs ----------------
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    check_reset_state("reset");
    reset = 1'b0;
    drive(1'b0, 6'h00, 1'b0, 1'b0);
    step();
    check_reset_state("idle_after_reset");

    // ---------------- routing ----------------
    drive(1'b1, 6'h05, 1'b0, 1'b0); step();
    drive(1'b1, 6'h15, 1'b0, 1'b0); step();
    check_eq("route.D0_empty", 32'(D0_empty), 32'h0);
    check_eq("route.D1_empty", 32'(D1_empty), 32'h0);
    drive(1'b0, 6'h00, 1'b1, 1'b1); step();
    check_eq("route.D0_valid", 32'(D0_valid),    32'h1);
    check_eq("route.D0_data",  32'(D0_data_out), 32'h05);
    check_eq("route.D1_valid", 32'(D1_valid),    32'h1);
    check_eq("route.D1_data",  32'(D1_data_out), 32'h15);
    drive(1'b0, 6'h00, 1'b0, 1'b0); step();
    check_eq("route.D0_valid_drop", 32'(D0_valid),    32'h0);
    check_eq("route.D0_data_hold",  32'(D0_data_out), 32'h05);
    check_eq("route.D0_empty_again", 32'(D0_empty),   32'h1);

    // ---------------- pause / full ----------------
    drive(1'b1, 6'h01, 1'b0, 1'b0); step();
    drive(1'b1, 6'h02, 1'b0, 1'b0); step();
    check_eq("pause.cnt2_D0_pause", 32'(D0_pause), 32'h0);
    drive(1'b1, 6'h03, 1'b0, 1'b0); step();
    check_eq("pause.cnt3_D0_pause", 32'(D0_pause), 32'h1);
    check_eq("pause.cnt3_D1_pause", 32'(D1_pause), 32'h0);
    check_eq("pause.cnt3_D0_full",  32'(D0_full),  32'h0);
    drive(1'b1, 6'h04, 1'b0, 1'b0); step();
    check_eq("pause.cnt4_D0_full", 32'(D0_full), 32'h1);
    check_eq("pause.cnt4_error",   32'(error),   32'h0);

    // ---------------- overflow ----------------
    drive(1'b1, 6'h0F, 1'b0, 1'b0); step();
    check_eq("ovf.error",   32'(error),   32'h1);
    check_eq("ovf.D0_full", 32'(D0_full), 32'h1);
    check_eq("ovf.D1_empty", 32'(D1_empty), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 6'h00, 1'b1, 1'b0); step();
      check_eq($sformatf("ovf.pop%0d_valid", i), 32'(D0_valid),    32'h1);
      check_eq($sformatf("ovf.pop%0d_data", i),  32'(D0_data_out), 32'(i));
    end
    check_eq("ovf.drained_empty", 32'(D0_empty), 32'h1);
    drive(1'b0, 6'h00, 1'b1, 1'b0); step();
    check_eq("ovf.pop_empty_valid", 32'(D0_valid),    32'h0);
    check_eq("ovf.pop_empty_hold",  32'(D0_data_out), 32'h04);
    check_eq("ovf.error_sticky",    32'(error),       32'h1);
    drive(1'b0, 6'h00, 1'b0, 1'b0); step();
    check_eq("ovf.error_still_sticky", 32'(error), 32'h1);
    reset = 1'b1; step();
    reset = 1'b0;
    check_reset_state("reset_clears");

    // ---------------- simultaneous write and pop on D1 ----------------
    drive(1'b1, 6'h11, 1'b0, 1'b0); step();
    drive(1'b1, 6'h12, 1'b0, 1'b0); step();
    drive(1'b1, 6'h13, 1'b0, 1'b1); step();
    check_eq("simul.D1_valid", 32'(D1_valid),    32'h1);
    check_eq("simul.D1_data",  32'(D1_data_out), 32'h11);
    check_eq("simul.cnt2_not_pause", 32'(D1_pause), 32'h0);
    check_eq("simul.cnt2_not_empty", 32'(D1_empty), 32'h0);
    check_eq("simul.D0_empty", 32'(D0_empty), 32'h1);
    drive(1'b0, 6'h00, 1'b0, 1'b1); step();
    check_eq("simul.order1", 32'(D1_data_out), 32'h12);
    check_eq("simul.cnt1_not_empty", 32'(D1_empty), 32'h0);
    drive(1'b0, 6'h00, 1'b0, 1'b1); step();
    check_eq("simul.order2", 32'(D1_data_out), 32'h13);
    check_eq("simul.empty",  32'(D1_empty),    32'h1);
    drive(1'b0, 6'h00, 1'b0, 1'b1); step();
    check_eq("simul.pop_empty_valid", 32'(D1_valid),    32'h0);
    check_eq("simul.pop_empty_hold",  32'(D1_data_out), 32'h13);

    // ---------------- wrap-around stream into D0 ----------------
    for (int i = 0; i < 10; i++) stream[i] = W'(32'h20 + i);
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(1'b1, stream[i], 1'b1, 1'b0);
      else        drive(1'b0, 6'h00,     1'b1, 1'b0);
      step();
      if (i == 0 || i == 11) begin
        check_eq($sformatf("wrap.c%0d_valid", i), 32'(D0_valid), 32'h0);
      end else begin
        check_eq($sformatf("wrap.c%0d_valid", i), 32'(D0_valid),    32'h1);
        check_eq($sformatf("wrap.c%0d_data", i),  32'(D0_data_out), 32'(stream[i-1]));
      end
      check_eq($sformatf("wrap.c%0d_pause", i), 32'(D0_pause), 32'h0);
    end
    check_eq("wrap.error", 32'(error),    32'h0);
    check_eq("wrap.empty", 32'(D0_empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dest_demux_fifos.md
# dest_demux_fifos

Downstream stage of the VC arbiter. It receives the word popped from VC0/VC1 one cycle after the pop, i.e. while `pop_delay_VC0`/`pop_delay_VC1` is high. It routes that word by its destination bit into one of two output FIFOs, D0 and D1. It generates the `D0_pause`/`D1_pause` back-pressure signals that the arbiter's pop logic samples combinationally.

## Interface
- `WIDTH`, 6, data word width.
- `DEPTH`, 4, entries per output FIFO (power of two).
- `DEST_BIT`, 4, index of the bit in `data_in` that selects the destination (0 → D0, 1 → D1).
- `AF_THRESH`, 3, almost-full level for pause generation; must satisfy `AF_THRESH ≤ DEPTH-1`.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `data_in` in WIDTH: word from the arbiter mux.
- `valid_in` in 1: `data_in` valid this cycle (= `pop_delay_VC0 | pop_delay_VC1`).
- `D0_pop` in 1: read request, FIFO D0.
- `D1_pop` in 1: read request, FIFO D1.
- `D0_data_out` out WIDTH: registered read data, D0.
- `D1_data_out` out WIDTH: registered read data, D1.
- `D0_valid` out 1: `D0_data_out` valid.
- `D1_valid` out 1: `D1_data_out` valid.
- `D0_empty`, `D1_empty` out 1: FIFO count == 0.
- `D0_full`, `D1_full` out 1: FIFO count == DEPTH.
- `D0_pause`, `D1_pause` out 1: FIFO count ≥ AF_THRESH.
- `error` out 1: sticky overflow flag.

## Operation
- **Write routing.** When `valid_in` is 1, `data_in` is written to D0 if `data_in[DEST_BIT]` is 0, otherwise to D1. Exactly one FIFO is written per valid word.
- **Read.** When `Dx_pop` is 1 and D*x* is not empty:
  - the head word is loaded into `Dx_data_out`;
  - `Dx_valid` is 1 on the next cycle;
  - the read pointer advances.
- **Pop while empty.** Ignored: no pointer move, `Dx_valid` is 0 next cycle, `Dx_data_out` holds its value.
- **Write to a full FIFO.** The word is dropped, the pointers are unchanged, and `error` is set to 1. `error` stays 1 until `reset`.
- **Simultaneous write and pop on the same FIFO:**
  - not empty: both occur and the count is unchanged;
  - empty: the pop is ignored and the write proceeds.
- **Simultaneous write and pop on a full FIFO:** the pop proceeds and the write is dropped with `error` set. The write check uses the pre-edge count.
- **Pointers.** Read and write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. The count is `log2(DEPTH)+1` bits, range 0..DEPTH.
- **Flags.** `Dx_empty`, `Dx_full` and `Dx_pause` are combinational decodes of the current count (no added latency). This is required because the arbiter samples pause in the same cycle.
- **Pause sizing.** A pop allowed in cycle t lands as a write at the end of cycle t+1. With up to two words in flight, `AF_THRESH ≤ DEPTH-1` guarantees no overflow under correct arbiter behaviour. `error` therefore indicates a protocol violation.

## Timing
- **Reset** (`reset`=1 at a rising edge): pointers and counts are cleared, and on the next cycle:
  - `Dx_data_out` = 0, `Dx_valid` = 0, `error` = 0;
  - `Dx_empty` = 1, `Dx_full` = 0, `Dx_pause` = 0.
- **Reset mid-operation.** Stored words are discarded and any concurrent `valid_in` or pop is ignored that cycle.
- **Write latency.** A word written at edge e is poppable in the cycle after e. The earliest `Dx_valid` is at edge e+2.
- **Read latency.** 1 cycle from `Dx_pop` to `Dx_valid`/`Dx_data_out`.
- **Throughput.** One write (to one FIFO) plus one pop per FIFO per cycle.

## Structure
- **Sub-module `fifo_sync`** (parameters WIDTH, DEPTH): instantiated twice.
  - Contents: register array, pointers, count, registered read port.
  - Outputs: `empty`, `full`, `count`, `overflow`.
- **Top level:** write demux, pause compare against `AF_THRESH`, and OR of the two overflows into the sticky `error`.
- **Shared package:**
  - `WIDTH`, `DEPTH`, `DEST_BIT` defaults;
  - destination encoding constants `DEST_D0 = 0` and `DEST_D1 = 1`.

## Test plan
- **Reset.** Hold `reset`=1 for 2 cycles with random inputs → all outputs are at reset values; `D0_empty` = `D1_empty` = 1.
- **Routing.** Write 0x05 (bit4=0) then 0x15 (bit4=1); pop both FIFOs next cycle → one cycle later `D0_data_out` = 0x05 and `D1_data_out` = 0x15, both valid.
- **Pause.** Write 3 words to D0 with no pops → `D0_pause` = 1 in the cycle count reaches 3, and `D1_pause` stays 0. Write a 4th → `D0_full` = 1, `error` = 0.
- **Overflow.** Write a 5th word to a full D0 → `error` = 1, count stays 4. Pop 4 times → data returns in order 1, 2, 3, 4 and the dropped word never appears.
- **Simultaneous write and pop.** Write and pop D1 together with count 2 → count stays 2 and FIFO order is preserved. Pop an empty D1 → `D1_valid` = 0.
- **Wrap-around.** Stream 10 words into D0 with a pop every cycle → output sequence matches input with 2-cycle latency, pointers wrap, no `error`.
